// File: rtl/mmio_led_sequencer_pkg.sv
// rtl/mmio_led_sequencer_pkg.sv - shared colour codes, MMIO addresses, FSM states and status layout
package mmio_led_sequencer_pkg;

    typedef enum logic [1:0] {
        COLOR_RED    = 2'b00,
        COLOR_BLUE   = 2'b01,
        COLOR_GREEN  = 2'b10,
        COLOR_YELLOW = 2'b11
    } color_e;

    localparam logic [11:0] ADDR_RAND     = 12'd5;
    localparam logic [11:0] ADDR_LED      = 12'd6;
    localparam logic [11:0] ADDR_LED_CTRL = 12'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_COUNT_W   = 4;
    localparam int STAT_OVF_BIT   = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mmio_led_sequencer_if.sv
// rtl/mmio_led_sequencer_if.sv - processor data-memory bus as seen by the LED sequencer
// Signals: wren/address_dmem/data driven by the processor (master),
//          q_status returned by the sequencer (slave), muxed onto q_dmem at address 7.
interface mmio_led_sequencer_if;
    logic        wren;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic [31:0] q_status;

    modport master (output wren, output address_dmem, output data, input q_status);
    modport slave  (input wren, input address_dmem, input data, output q_status);
endinterface

// File: rtl/mmio_led_sequencer_sync_fifo.sv
// rtl/mmio_led_sequencer_sync_fifo.sv - synchronous FIFO with clear, count, full and empty
// Ports: i_clk, i_rst_n (async active-low), i_clear (empties at the edge),
//        i_push/i_wdata, i_pop, o_rdata (head, combinational), o_count, o_full, o_empty.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_COUNT);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mmio_led_sequencer.sv
// rtl/mmio_led_sequencer.sv - queued LED flash scheduler behind MMIO stores
// Ports: clock, reset (async active-low), bus (slave: wren/address_dmem/data in, q_status out),
//        red_led/blue_led/green_led/yellow_led (registered), busy (queue non-empty or playing).
module mmio_led_sequencer #(
    parameter int DEPTH      = 8,
    parameter int ON_CYCLES  = 25000000,
    parameter int GAP_CYCLES = 12500000
) (
    input  logic                 clock,
    input  logic                 reset,
    mmio_led_sequencer_if.slave  bus,
    output logic                 red_led,
    output logic                 blue_led,
    output logic                 green_led,
    output logic                 yellow_led,
    output logic                 busy
);
    import mmio_led_sequencer_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(max_int(ON_CYCLES, GAP_CYCLES) + 1);

    logic          w_push;
    logic          w_abort;
    logic          w_pop;
    logic [1:0]    w_fifo_rdata;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    state_e        r_state;
    state_e        w_state_next;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_next;
    color_e        r_color;
    color_e        w_color_next;
    logic [3:0]    r_led;
    logic [3:0]    w_led_next;
    logic          r_overflow;
    logic [31:0]   w_count_ext;
    logic [3:0]    w_count_sat;
    logic [31:0]   w_status;
    logic          w_unused_data;

    assign w_push        = bus.wren && (bus.address_dmem == ADDR_LED);
    assign w_abort       = bus.wren && (bus.address_dmem == ADDR_LED_CTRL) && bus.data[0];
    assign w_unused_data = ^bus.data[31:3];

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(2)) u_fifo (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_clear (w_abort),
        .i_push  (w_push),
        .i_wdata (bus.data[2:1]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_color <= COLOR_RED;
            r_led   <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_color <= w_color_next;
            r_led   <= w_led_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_color_next = r_color;
        w_pop        = 1'b0;
        if (w_abort) begin
            // Abort wins over any pop that would have happened this edge.
            w_state_next = ST_IDLE;
            w_timer_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_color_next = color_e'(w_fifo_rdata);
                        w_timer_next = TW'(ON_CYCLES - 1);
                        w_state_next = ST_ON;
                    end
                end
                ST_ON: begin
                    if (r_timer == '0) begin
                        w_timer_next = TW'(GAP_CYCLES - 1);
                        w_state_next = ST_GAP;
                    end else begin
                        w_timer_next = r_timer - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_timer == '0) begin
                        // Chain straight into the next flash so back-to-back colours have no idle cycle.
                        if (!w_empty) begin
                            w_pop        = 1'b1;
                            w_color_next = color_e'(w_fifo_rdata);
                            w_timer_next = TW'(ON_CYCLES - 1);
                            w_state_next = ST_ON;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_timer_next = r_timer - 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_timer_next = '0;
                end
            endcase
        end
    end

    // LED drive is computed from the next state and registered, so the pins never glitch.
    always_comb begin
        w_led_next = '0;
        if (w_state_next == ST_ON) begin
            w_led_next[w_color_next] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_abort) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign red_led    = r_led[COLOR_RED];
    assign blue_led   = r_led[COLOR_BLUE];
    assign green_led  = r_led[COLOR_GREEN];
    assign yellow_led = r_led[COLOR_YELLOW];
    assign busy       = !w_empty || (r_state != ST_IDLE);

    assign w_count_ext = 32'(w_count);
    assign w_count_sat = (w_count_ext > 32'd15) ? 4'hF : w_count_ext[3:0];

    always_comb begin
        w_status                                     = '0;
        w_status[STAT_BUSY_BIT]                      = busy;
        w_status[STAT_COUNT_LSB +: STAT_COUNT_W]     = w_count_sat;
        w_status[STAT_OVF_BIT]                       = r_overflow;
    end

    assign bus.q_status = w_status;
endmodule

// File: doc/mmio_led_sequencer.md
Name: mmio_led_sequencer

Overview:
Memory-mapped scheduler for the four game LEDs. The processor issues back-to-back stores of colour codes without software delay loops. The block queues them in a FIFO and plays each colour for a fixed on-time followed by a fixed dark gap. A status word readable at address 7 lets software poll for completion before it samples the buttons.

Parameters:
DEPTH, 8, FIFO entries (power of two, >=2)
ON_CYCLES, 25000000, clock cycles each LED stays lit (>=1)
GAP_CYCLES, 12500000, clock cycles of darkness after each flash (>=1)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
wren  input  1  processor data-memory write enable
address_dmem  input  12  processor data-memory address
data  input  32  processor store data
q_status  output  32  status word, combinational; system muxes it onto q_dmem when address_dmem==7
red_led  output  1  red LED drive
blue_led  output  1  blue LED drive
green_led  output  1  green LED drive
yellow_led  output  1  yellow LED drive
busy  output  1  1 while FIFO non-empty or state != IDLE

Behaviour:
- Push: wren && address_dmem==6 → colour = data[2:1] (00 red, 01 blue, 10 green, 11 yellow), enqueued at the edge. Other data bits are ignored.
- Push when count==DEPTH with no pop the same edge → dropped; sticky overflow set. If a pop occurs the same edge, the push is accepted and count is unchanged.
- Control: wren && address_dmem==7 && data[0]==1 → at the edge: FIFO emptied, state→IDLE, LEDs off, overflow cleared, timer zeroed.
  - Abort takes priority over an in-progress pop.
  - Writes to address 7 with data[0]==0 have no effect.
- Other addresses are ignored.
- Status: q_status = {23'b0, overflow[8], count[7:4] (saturating at 15 for DEPTH>15), 3'b0, busy[0]}.
- FSM states: IDLE, ON, GAP. Timer width is $clog2(max(ON_CYCLES, GAP_CYCLES)+1).
  - IDLE: if count>0 → pop head, latch colour, timer=ON_CYCLES-1, →ON. Otherwise stay.
  - ON: exactly the latched LED is 1. If timer==0 → timer=GAP_CYCLES-1, →GAP. Otherwise decrement.
  - GAP: all LEDs 0. If timer==0 → (count>0 ? pop, timer=ON_CYCLES-1, →ON : →IDLE). Otherwise decrement.
- Latency: a push sampled at edge E into an empty, idle block → LED high after edge E+1, for exactly ON_CYCLES cycles, then GAP_CYCLES dark. Back-to-back flashes have a period of exactly ON_CYCLES+GAP_CYCLES with no idle cycle between them.
- FIFO: read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- Reset (asynchronous, any time, including mid-flash): state=IDLE, count=0, pointers=0, overflow=0, timer=0, all LEDs 0, busy=0, q_status=0.
- Never more than one LED high; LEDs are registered outputs (glitch-free).

Decomposition:
- Shared package holds:
  - colour codes (COLOR_RED=2'b00, COLOR_BLUE=2'b01, COLOR_GREEN=2'b10, COLOR_YELLOW=2'b11)
  - MMIO addresses (ADDR_RAND=12'd5, ADDR_LED=12'd6, ADDR_LED_CTRL=12'd7)
  - FSM state encoding
  - status bit positions
- One sub-module: sync_fifo (DEPTH, WIDTH=2; push/pop/clear, count/full/empty outputs), reusable for future button-input queueing.
- FSM and timer stay in the top.

Test Plan (bench: ON_CYCLES=4, GAP_CYCLES=2, DEPTH=4):
- Single flash: reset low 2 cycles, release; store 32'h4 to addr 6 → green_led high cycles 2–5 after the write edge, low after; busy 1 through the gap, then 0; q_status=0.
- Back-to-back: stores 0,2,4,6 on consecutive cycles → red, blue, green, yellow each lit 4 cycles, 2-cycle gaps, total 24 cycles; q_status[7:4] peaks at 3 after the first pop.
- Overflow: 6 consecutive stores while the first flash is playing → 5 accepted (1 playing + 4 queued), 6th dropped; q_status[8]=1 and stays 1 until a 32'h1 store to addr 7 clears it.
- Abort mid-ON: queue 3 colours, store 32'h1 to addr 7 during the 2nd cycle of the first flash → all LEDs 0 and q_status=0 at the next edge; nothing further plays.
- Push while full with a simultaneous pop: FIFO full, push on the cycle GAP ends → accepted, count stays 4, and the new colour plays last in order.
- Async reset mid-flash: drop reset between clock edges while blue is lit → LED low immediately (before the next edge), q_status=0, busy=0; after release, no stale colours play.
